branch_resolver: RTL and testbench
==================================

# branch_resolver

Sequential branch-resolution unit for the pipelined core. It accepts one branch or jump per handshake, together with the comparator flags for its operands. It decides taken/not-taken from `funct3` and, on taken, runs a fixed-length pipeline flush followed by a redirect handshake to fetch. It also keeps saturating taken/not-taken statistics counters.

## Interface
Parameters:
- `Width`, 32, datapath/PC width
- `FlushCycles`, 2, cycles `flush` is held high per taken branch (legal range ≥1)
- `CntWidth`, 16, width of each statistics counter

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `br_valid`  in  1  branch request valid
- `br_ready`  out  1  unit can accept a request
- `br_is_jump`  in  1  unconditional (JAL/JALR); `funct3` ignored
- `br_funct3`  in  3  branch condition code
- `br_pc`  in  Width  PC of the branch
- `br_imm`  in  Width  sign-extended offset
- `cmp_eq`  in  1  operands equal
- `cmp_lt_s`  in  1  rs1 < rs2, signed
- `cmp_lt_u`  in  1  rs1 < rs2, unsigned
- `flush`  out  1  kill younger pipeline stages
- `redir_valid`  out  1  redirect target valid
- `redir_ready`  in  1  fetch accepts redirect
- `redir_pc`  out  Width  redirect target
- `illegal`  out  1  one-cycle pulse on an illegal `funct3`
- `taken_cnt`  out  CntWidth  taken count
- `ntaken_cnt`  out  CntWidth  not-taken count

## Operation
- FSM states: IDLE, FLUSH, REDIR.
- `br_ready` = 1 only in IDLE. Acceptance = `br_valid && br_ready`. All `br_*` and `cmp_*` inputs are sampled only on acceptance.
- Condition decode (`br_is_jump`=0):
  - 000 → `eq`
  - 001 → `!eq`
  - 100 → `lt_s`
  - 101 → `!lt_s`
  - 110 → `lt_u`
  - 111 → `!lt_u`
  - 010, 011 → illegal
- `br_is_jump`=1 → taken regardless of flags or `funct3`.
- Illegal: `illegal` pulses the cycle after acceptance; no counter change; FSM stays IDLE.
- Not taken: `ntaken_cnt`+1; FSM stays IDLE.
- Taken: `taken_cnt`+1; the target is latched and the FSM goes to FLUSH.
- Target = (`br_pc` + `br_imm`) mod 2^Width, then bit 0 forced to 0.
- FLUSH: `flush`=1. A down-counter loaded with FlushCycles−1 decrements each cycle; at 0 the FSM goes to REDIR.
- REDIR: `redir_valid`=1 and `redir_pc` holds stable until `redir_ready`. On the handshake cycle the FSM returns to IDLE.
- Counters saturate at all-ones and never wrap.
- Reset values: state IDLE, `br_ready`=1, `flush`=0, `redir_valid`=0, `redir_pc`=0, `illegal`=0, both counters 0.
- Reset asserted mid-FLUSH or mid-REDIR aborts immediately. No redirect is emitted after reset release.

## Timing
- All outputs are registered except `br_ready`, which is decoded from state.
- Taken branch accepted at cycle t:
  - `flush` high during t+1 … t+FlushCycles
  - `redir_valid` high from t+FlushCycles+1
  - next acceptance no earlier than the cycle after the `redir_ready` handshake
- Not-taken or illegal: back-to-back acceptance every cycle. Counter and `illegal` update visible at t+1.
- `redir_ready` held high before REDIR has no effect. `redir_ready` high on the first REDIR cycle → `redir_valid` lasts exactly 1 cycle.
- `flush` and `redir_valid` are never high in the same cycle.

## Structure
- Shared package `riscv_branch_pkg`:
  - `funct3` localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - FSM state encoding typedef
- One natural sub-module, `sat_counter` (parameter CntWidth, inputs `inc`/`clk`/`rst_n`), instantiated twice for the statistics counters.
- Target adder and condition decode stay inline.

## Test plan
- Reset then idle: all outputs at reset values; `br_ready`=1; counters 0.
- BEQ, `cmp_eq`=1, pc=0x100, imm=0x20, FlushCycles=2:
  - `flush` at t+1, t+2
  - `redir_valid` at t+3 with `redir_pc`=0x120
  - `taken_cnt`=1
- BLTU with `cmp_lt_u`=0, then BGE with `cmp_lt_s`=0, on consecutive cycles:
  - first (BLTU) not taken, no flush
  - second (BGE) taken
  - `ntaken_cnt`=1, `taken_cnt`=1
- JAL (`br_is_jump`=1), pc=0xFFFF_FFF0, imm=0x13, `redir_ready` low for 3 cycles:
  - `redir_pc`=0x0000_0002 (wrapped, bit 0 cleared)
  - held stable until ready
- `funct3`=010: `illegal` pulses 1 cycle; counters unchanged; no flush.
- CntWidth=2 with 5 not-taken branches: `ntaken_cnt` sticks at 3.
- Reset pulsed during FLUSH: `flush` drops at once; `redir_valid` never rises.

Source files
------------

// File: rtl/riscv_branch_pkg.sv
// Shared definitions for the branch resolution unit.
//   - funct3 condition codes for conditional branches
//   - FSM state type and encodings (IDLE, FLUSH, REDIR)
package riscv_branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef logic [1:0] br_state_t;

    localparam br_state_t ST_IDLE  = 2'd0;
    localparam br_state_t ST_FLUSH = 2'd1;
    localparam br_state_t ST_REDIR = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the branch statistics.
// Ports:
//   clk    - clock, counts on rising edge
//   rst_n  - asynchronous active-low reset, clears count
//   inc    - add one this cycle (ignored once count is all-ones)
//   count  - current value
module sat_counter #(
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    output logic [CntWidth-1:0] count
);

    localparam logic [CntWidth-1:0] One = {{(CntWidth-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + One;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolution unit. Accepts one branch/jump per handshake, decides
// taken/not-taken from funct3 and the comparator flags, and on a taken
// branch holds flush for FlushCycles cycles then offers a redirect to fetch.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   br_valid / br_ready        - request handshake (br_ready only in IDLE)
//   br_is_jump, br_funct3      - unconditional flag, condition code
//   br_pc, br_imm              - branch PC and sign-extended offset
//   cmp_eq, cmp_lt_s, cmp_lt_u - operand comparator flags
//   flush                      - kill younger stages
//   redir_valid / redir_ready  - redirect handshake, redir_pc is the target
//   illegal                    - one-cycle pulse on an illegal funct3
//   taken_cnt, ntaken_cnt      - saturating statistics
//   dbg_state                  - current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid (and its payload) until the transfer;
// ready may change freely and has no effect while valid is low.
module branch_resolver
    import riscv_branch_pkg::*;
#(
    parameter int Width       = 32,
    parameter int FlushCycles = 2,
    parameter int CntWidth    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                br_valid,
    output logic                br_ready,
    input  logic                br_is_jump,
    input  logic [2:0]          br_funct3,
    input  logic [Width-1:0]    br_pc,
    input  logic [Width-1:0]    br_imm,
    input  logic                cmp_eq,
    input  logic                cmp_lt_s,
    input  logic                cmp_lt_u,
    output logic                flush,
    output logic                redir_valid,
    input  logic                redir_ready,
    output logic [Width-1:0]    redir_pc,
    output logic                illegal,
    output logic [CntWidth-1:0] taken_cnt,
    output logic [CntWidth-1:0] ntaken_cnt,
    output br_state_t           dbg_state
);

    localparam int FcW = ($clog2(FlushCycles) > 0) ? $clog2(FlushCycles) : 1;
    localparam logic [FcW-1:0] FcLoad = FcW'(FlushCycles - 1);
    localparam logic [FcW-1:0] FcOne  = FcW'(1);

    br_state_t        state;
    logic [FcW-1:0]   fcnt;
    logic             accept;
    logic             cond_taken;
    logic             is_illegal;
    logic             take;
    logic             ntake;
    logic [Width-1:0] target_sum;
    logic [Width-1:0] target;

    assign br_ready  = (state == ST_IDLE);
    assign accept    = br_valid && br_ready;
    assign dbg_state = state;

    always_comb begin
        cond_taken = 1'b0;
        is_illegal = 1'b0;
        case (br_funct3)
            BEQ:     cond_taken = cmp_eq;
            BNE:     cond_taken = !cmp_eq;
            BLT:     cond_taken = cmp_lt_s;
            BGE:     cond_taken = !cmp_lt_s;
            BLTU:    cond_taken = cmp_lt_u;
            BGEU:    cond_taken = !cmp_lt_u;
            default: is_illegal = 1'b1;
        endcase
        // Jumps ignore funct3 entirely, including the illegal encodings.
        if (br_is_jump) begin
            cond_taken = 1'b1;
            is_illegal = 1'b0;
        end
    end

    assign take  = accept && !is_illegal && cond_taken;
    assign ntake = accept && !is_illegal && !cond_taken;

    // Wraps modulo 2^Width; bit 0 is cleared as JALR requires.
    assign target_sum = br_pc + br_imm;
    assign target     = {target_sum[Width-1:1], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fcnt        <= '0;
            flush       <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            illegal     <= 1'b0;
        end else begin
            illegal <= accept && is_illegal;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state    <= ST_FLUSH;
                        flush    <= 1'b1;
                        fcnt     <= FcLoad;
                        redir_pc <= target;
                    end
                end
                ST_FLUSH: begin
                    // Last flush cycle hands straight over to the redirect so
                    // flush and redir_valid never overlap.
                    if (fcnt == '0) begin
                        state       <= ST_REDIR;
                        flush       <= 1'b0;
                        redir_valid <= 1'b1;
                    end else begin
                        fcnt <= fcnt - FcOne;
                    end
                end
                ST_REDIR: begin
                    if (redir_ready) begin
                        state       <= ST_IDLE;
                        redir_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    flush       <= 1'b0;
                    redir_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.CntWidth(CntWidth)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take),
        .count (taken_cnt)
    );

    sat_counter #(.CntWidth(CntWidth)) u_ntaken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ntake),
        .count (ntaken_cnt)
    );

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver. Two instances share all inputs: one with the
// default 16-bit counters, one with 2-bit counters to exercise saturation.
// The reference model works on real operand values and a cycle timeline
// (edge of acceptance, flush window, pending redirect).
module tb_branch_resolver;

    localparam int W  = 32;
    localparam int FC = 2;

    logic          clk;
    logic          rst_n;
    logic          br_valid;
    logic          br_is_jump;
    logic [2:0]    br_funct3;
    logic [W-1:0]  br_pc;
    logic [W-1:0]  br_imm;
    logic          cmp_eq;
    logic          cmp_lt_s;
    logic          cmp_lt_u;
    logic          redir_ready;

    logic          br_ready,    br_ready_s;
    logic          flush,       flush_s;
    logic          redir_valid, redir_valid_s;
    logic [W-1:0]  redir_pc,    redir_pc_s;
    logic          illegal,     illegal_s;
    logic [15:0]   taken_cnt,   ntaken_cnt;
    logic [1:0]    taken_cnt_s, ntaken_cnt_s;
    logic [1:0]    dbg_state,   dbg_state_s;

    int n_checks;
    int n_fail;

    // Reference model state
    bit           m_pend;
    int           m_acc;
    int           m_edge;
    logic [W-1:0] m_tgt;
    bit           m_ill;
    int           m_tk;
    int           m_nt;

    branch_resolver #(.Width(W), .FlushCycles(FC), .CntWidth(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready),
        .br_is_jump(br_is_jump), .br_funct3(br_funct3),
        .br_pc(br_pc), .br_imm(br_imm),
        .cmp_eq(cmp_eq), .cmp_lt_s(cmp_lt_s), .cmp_lt_u(cmp_lt_u),
        .flush(flush), .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_pc(redir_pc), .illegal(illegal),
        .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt),
        .dbg_state(dbg_state)
    );

    branch_resolver #(.Width(W), .FlushCycles(FC), .CntWidth(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready_s),
        .br_is_jump(br_is_jump), .br_funct3(br_funct3),
        .br_pc(br_pc), .br_imm(br_imm),
        .cmp_eq(cmp_eq), .cmp_lt_s(cmp_lt_s), .cmp_lt_u(cmp_lt_u),
        .flush(flush_s), .redir_valid(redir_valid_s), .redir_ready(redir_ready),
        .redir_pc(redir_pc_s), .illegal(illegal_s),
        .taken_cnt(taken_cnt_s), .ntaken_cnt(ntaken_cnt_s),
        .dbg_state(dbg_state_s)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int width);
        int top;
        top = (1 << width) - 1;
        return (v > top) ? top : v;
    endfunction

    // Compare everything visible after the most recent edge with the model.
    task automatic check_outputs();
        bit exp_flush;
        bit exp_redir;
        exp_flush = m_pend && ((m_edge - m_acc) < FC);
        exp_redir = m_pend && ((m_edge - m_acc) >= FC);
        check_eq("br_ready",      br_ready,      !m_pend);
        check_eq("flush",         flush,         exp_flush);
        check_eq("redir_valid",   redir_valid,   exp_redir);
        check_eq("redir_pc",      redir_pc,      m_tgt);
        check_eq("illegal",       illegal,       m_ill);
        check_eq("taken_cnt",     taken_cnt,     sat(m_tk, 16));
        check_eq("ntaken_cnt",    ntaken_cnt,    sat(m_nt, 16));
        check_eq("flush_s",       flush_s,       exp_flush);
        check_eq("redir_valid_s", redir_valid_s, exp_redir);
        check_eq("taken_cnt_s",   taken_cnt_s,   sat(m_tk, 2));
        check_eq("ntaken_cnt_s",  ntaken_cnt_s,  sat(m_nt, 2));
        check_eq("no_overlap",    flush && redir_valid, 1'b0);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: check, drive the next cycle's inputs, advance the
    // model across the coming rising edge, and return at the next negedge.
    task automatic step(input bit v, input bit j, input logic [2:0] f3,
                        input logic [W-1:0] pc, input logic [W-1:0] imm,
                        input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                        input bit rr);
        bit acc;
        bit tk;
        bit ill;
        bit exp_redir;
        check_outputs();

        br_valid    = v;
        br_is_jump  = j;
        br_funct3   = f3;
        br_pc       = pc;
        br_imm      = imm;
        cmp_eq      = (rs1 == rs2);
        cmp_lt_s    = ($signed(rs1) < $signed(rs2));
        cmp_lt_u    = (rs1 < rs2);
        redir_ready = rr;

        acc       = v && !m_pend;
        exp_redir = m_pend && ((m_edge - m_acc) >= FC);
        if (exp_redir && rr) m_pend = 1'b0;

        m_ill = 1'b0;
        if (acc) begin
            ill = 1'b0;
            tk  = 1'b0;
            if (j) begin
                tk = 1'b1;
            end else begin
                case (f3)
                    3'd0: tk = (rs1 == rs2);
                    3'd1: tk = (rs1 != rs2);
                    3'd4: tk = ($signed(rs1) <  $signed(rs2));
                    3'd5: tk = ($signed(rs1) >= $signed(rs2));
                    3'd6: tk = (rs1 <  rs2);
                    3'd7: tk = (rs1 >= rs2);
                    default: ill = 1'b1;
                endcase
            end
            if (ill) begin
                m_ill = 1'b1;
            end else if (tk) begin
                m_tk++;
                m_pend = 1'b1;
                m_acc  = m_edge + 1;
                m_tgt  = (pc + imm) & ~32'd1;
            end else begin
                m_nt++;
            end
        end
        m_edge++;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 1'b0, 3'd0, '0, '0, '0, '0, rr);
    endtask

    // Asserts reset at a negedge, checks the asynchronous clear, then
    // releases at the following negedge.
    task automatic do_reset();
        rst_n       = 1'b0;
        br_valid    = 1'b0;
        redir_ready = 1'b0;
        #1;
        check_eq("rst_flush",       flush,       1'b0);
        check_eq("rst_redir_valid", redir_valid, 1'b0);
        check_eq("rst_br_ready",    br_ready,    1'b1);
        check_eq("rst_redir_pc",    redir_pc,    32'd0);
        check_eq("rst_illegal",     illegal,     1'b0);
        check_eq("rst_taken_cnt",   taken_cnt,   16'd0);
        check_eq("rst_ntaken_cnt",  ntaken_cnt,  16'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_pend = 1'b0;
        m_acc  = 0;
        m_edge = 0;
        m_tgt  = '0;
        m_ill  = 1'b0;
        m_tk   = 0;
        m_nt   = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        br_valid    = 1'b0;
        br_is_jump  = 1'b0;
        br_funct3   = 3'd0;
        br_pc       = '0;
        br_imm      = '0;
        cmp_eq      = 1'b0;
        cmp_lt_s    = 1'b0;
        cmp_lt_u    = 1'b0;
        redir_ready = 1'b0;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) idle(1'b1);

        // BEQ taken: flush t+1,t+2, redirect at t+3 to 0x120
        do_reset();
        step(1'b1, 1'b0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
        check_eq("beq_flush1", flush, 1'b1);
        check_eq("beq_taken",  taken_cnt, 16'd1);
        idle(1'b0);
        check_eq("beq_flush2", flush, 1'b1);
        idle(1'b0);
        check_eq("beq_redir",  redir_valid, 1'b1);
        check_eq("beq_pc",     redir_pc, 32'h120);
        check_eq("beq_noflush", flush, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // BLTU not taken then BGE taken on consecutive cycles
        do_reset();
        step(1'b1, 1'b0, 3'b110, 32'h300, 32'h8, 32'd7, 32'd3, 1'b1);
        check_eq("bltu_noflush", flush, 1'b0);
        check_eq("bltu_ready",   br_ready, 1'b1);
        step(1'b1, 1'b0, 3'b101, 32'h200, 32'h40, 32'd3, 32'd1, 1'b1);
        check_eq("bge_flush",  flush, 1'b1);
        check_eq("bge_taken",  taken_cnt, 16'd1);
        check_eq("bge_ntaken", ntaken_cnt, 16'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // JAL with wrapping target, redirect held while fetch stalls
        do_reset();
        step(1'b1, 1'b1, 3'b010, 32'hFFFF_FFF0, 32'h13, 32'd0, 32'd9, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check_eq("jal_hold_valid", redir_valid, 1'b1);
            check_eq("jal_hold_pc",    redir_pc, 32'h0000_0002);
        end
        idle(1'b1);
        check_eq("jal_done", redir_valid, 1'b0);
        idle(1'b0);

        // Illegal funct3
        do_reset();
        step(1'b1, 1'b0, 3'b010, 32'h40, 32'h4, 32'd1, 32'd1, 1'b0);
        check_eq("ill_pulse",  illegal, 1'b1);
        check_eq("ill_flush",  flush, 1'b0);
        check_eq("ill_taken",  taken_cnt, 16'd0);
        check_eq("ill_ntaken", ntaken_cnt, 16'd0);
        idle(1'b0);
        check_eq("ill_clear", illegal, 1'b0);

        // Saturation on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 3'b000, 32'h80, 32'h4, 32'd1, 32'd2, 1'b0);
        check_eq("sat_ntaken_s", ntaken_cnt_s, 2'd3);
        check_eq("sat_ntaken",   ntaken_cnt, 16'd5);
        idle(1'b0);

        // Reset during FLUSH aborts without a later redirect
        do_reset();
        step(1'b1, 1'b0, 3'b001, 32'h500, 32'h10, 32'd1, 32'd2, 1'b1);
        idle(1'b1);
        check_eq("mid_flush", flush, 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] rs1;
            logic [W-1:0] rs2;
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
                 3'($urandom_range(0, 7)), $urandom, $urandom,
                 rs1, rs2, $urandom_range(0, 1) == 1);
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
